cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
//
// PURPOSE
//  Sequencer between the MIPS core's load/fetch port and the 2-way set-associative cache.
//  - Accepts one CPU read at a time and issues a single lookup to the cache.
//  - On a miss, fetches the word from main memory over a valid/ready handshake and writes it into the cache.
//  - Returns data to the CPU and keeps saturating hit/miss statistics.
//
// PARAMETERS
//  ADDR_W       32   address width (byte address)
//  DATA_W       32   data word width
//  CNT_W        16   width of hit/miss statistic counters
//  MEM_TIMEOUT  255  max cycles from MEM_REQ entry to mem response before error
//
// PORTS
//  clk             in   1       system clock, all logic on posedge
//  rst             in   1       synchronous, active-low reset
//  cpu_req_valid   in   1       CPU read request valid
//  cpu_req_ready   out  1       controller can accept request (high only in IDLE)
//  cpu_addr        in   ADDR_W  CPU byte address
//  cpu_resp_valid  out  1       one-cycle pulse, response data valid
//  cpu_resp_data   out  DATA_W  read data
//  cpu_resp_hit    out  1       response was a cache hit
//  cpu_resp_err    out  1       memory timeout; data forced to 0
//  lk_en           out  1       cache lookup strobe
//  lk_addr         out  ADDR_W  lookup address, word aligned ({addr[31:2],2'b00})
//  lk_hit          in   1       cache hit, valid the cycle after lk_en
//  lk_data         in   DATA_W  cache hit data, valid with lk_hit
//  fill_en         out  1       cache fill strobe; cache selects victim by LRU
//  fill_addr       out  ADDR_W  fill address (word aligned)
//  fill_data       out  DATA_W  fill data
//  mem_req_valid   out  1       memory read request valid
//  mem_req_ready   in   1       memory accepts request
//  mem_addr        out  ADDR_W  memory read address (word aligned)
//  mem_resp_valid  in   1       memory read data valid
//  mem_resp_data   in   DATA_W  memory read data
//  hit_cnt         out  CNT_W   saturating count of hits
//  miss_cnt        out  CNT_W   saturating count of misses
//
// BEHAVIOUR
//  - Reset (rst==0 at posedge):
//    - state <= IDLE.
//    - All registered outputs, counters, the address latch and the timeout counter are cleared to 0.
//    - cpu_req_ready is 0 while rst==0.
//  - FSM states: IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP.
//  - IDLE:
//    - cpu_req_ready=1.
//    - On cpu_req_valid&&cpu_req_ready, latch word-aligned cpu_addr and go to LOOKUP.
//  - LOOKUP: lk_en=1 for exactly one cycle with lk_addr = latched address; go to CHECK.
//  - CHECK: sample lk_hit and lk_data.
//    - Hit: capture data, set resp_hit=1, increment hit_cnt, go to RESP.
//    - Miss: increment miss_cnt, clear the timeout counter, go to MEM_REQ.
//  - MEM_REQ:
//    - mem_req_valid=1, with mem_addr held stable until mem_req_ready.
//    - On the handshake, go to MEM_WAIT.
//    - A mem_resp_valid seen in this state is ignored.
//  - MEM_WAIT: on mem_resp_valid, capture mem_resp_data and go to FILL.
//  - FILL:
//    - fill_en=1 for one cycle, with fill_addr = latched address and fill_data = captured data.
//    - Go to RESP with resp_hit=0.
//  - RESP:
//    - cpu_resp_valid=1 for one cycle; there is no CPU backpressure.
//    - Data, hit and err are held stable in this cycle, then the FSM returns to IDLE.
//  - Timeout:
//    - The counter increments every cycle in MEM_REQ and MEM_WAIT.
//    - When it reaches MEM_TIMEOUT without mem_resp_valid, go to RESP with err=1, data=0, hit=0 and no fill.
//    - A late mem_resp_valid arriving in IDLE is ignored.
//    - If mem_resp_valid coincides with the timeout cycle, the response wins (no error).
//  - Latency, counted from the accepting edge:
//    - Hit: resp_valid in cycle +3.
//    - Miss: resp_valid 2 cycles after the mem_resp_valid edge (FILL, RESP).
//  - Only one request is in flight at a time; cpu_req_valid outside IDLE is not accepted.
//  - Statistic counters saturate at all ones and never wrap; only reset clears them.
//  - Reset mid-operation aborts immediately: no fill_en, no cpu_resp_valid, and mem_req_valid drops the next cycle.
//  - lk_en, fill_en, mem_req_valid and cpu_resp_valid are never high simultaneously.
//
// TESTING
//  1. Reset, then request 0x0000_0040 with lk_hit=1 and lk_data=0xDEAD_BEEF
//     -> lk_en in cycle +1; resp_valid in cycle +3 with data 0xDEADBEEF, hit=1; hit_cnt=1.
//  2. Miss on 0x0000_0104; mem_req_ready=1 at once; mem_resp 0x41 after 5 cycles
//     -> fill_en with 0x104/0x41, then resp data 0x41, hit=0; miss_cnt=1.
//  3. Miss with mem_req_ready held low for 4 cycles
//     -> mem_req_valid and mem_addr stay stable all 4 cycles; only one request is issued.
//  4. Miss with MEM_TIMEOUT=8 and no mem response
//     -> resp err=1, data=0; no fill_en; a late mem_resp_valid in IDLE is ignored.
//  5. rst=0 pulsed in MEM_WAIT
//     -> no fill_en or resp; FSM in IDLE; counters 0; the next request completes normally.
//  6. CNT_W=2, five consecutive hits
//     -> hit_cnt reads 3 and holds; cpu_req_ready is low from the accept until after RESP.

Source files
------------

// File: rtl/cache_miss_ctrl_if.sv
// rtl/cache_miss_ctrl_if.sv - CPU, cache lookup/fill, memory and statistics bundle for cache_miss_ctrl
interface cache_miss_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_data;
    logic              cpu_resp_hit;
    logic              cpu_resp_err;

    logic              lk_en;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;

    logic              fill_en;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    // slave: the controller side; master: the CPU/cache/memory environment
    modport slave (
        input  cpu_req_valid, cpu_addr, lk_hit, lk_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit, cpu_resp_err,
        output lk_en, lk_addr, fill_en, fill_addr, fill_data,
        output mem_req_valid, mem_addr, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req_valid, cpu_addr, lk_hit, lk_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit, cpu_resp_err,
        input  lk_en, lk_addr, fill_en, fill_addr, fill_data,
        input  mem_req_valid, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - single-outstanding read sequencer between CPU, 2-way cache and main memory
module cache_miss_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_miss_ctrl_if.slave      bus
);
    localparam int                TMO_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              hit_q,      hit_d;
    logic              err_q,      err_d;
    logic [TMO_W-1:0]  tmo_q,      tmo_d;
    logic [CNT_W-1:0]  hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hit_d      = hit_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req_valid) begin
                    addr_d  = bus.cpu_addr & ALIGN_MASK;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                if (bus.lk_hit) begin
                    data_d  = bus.lk_data;
                    hit_d   = 1'b1;
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    tmo_d   = '0;
                    state_d = MEM_REQ;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
            end
            MEM_REQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                // The budget covers the request phase too, so a stuck
                // mem_req_ready cannot hang the CPU.
                if (tmo_q == TMO_LAST) begin
                    data_d  = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (bus.mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A response on the final cycle still wins over the timeout.
                if (bus.mem_resp_valid) begin
                    data_d  = bus.mem_resp_data;
                    state_d = FILL;
                end else if (tmo_q == TMO_LAST) begin
                    data_d  = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            FILL: begin
                hit_d   = 1'b0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_req_ready  = rst && (state_q == IDLE);
    assign bus.cpu_resp_valid = (state_q == RESP);
    assign bus.cpu_resp_data  = data_q;
    assign bus.cpu_resp_hit   = hit_q;
    assign bus.cpu_resp_err   = err_q;

    assign bus.lk_en          = (state_q == LOOKUP);
    assign bus.lk_addr        = addr_q;

    assign bus.fill_en        = (state_q == FILL);
    assign bus.fill_addr      = addr_q;
    assign bus.fill_data      = data_q;

    assign bus.mem_req_valid  = (state_q == MEM_REQ);
    assign bus.mem_addr       = addr_q;

    assign bus.hit_cnt        = hit_cnt_q;
    assign bus.miss_cnt       = miss_cnt_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed self-checking bench for cache_miss_ctrl
module tb_cache_miss_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   fill_cnt = 0;
    int   mem_hs = 0;
    int   excl_viol = 0;

    always #5 clk = ~clk;

    cache_miss_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) bus ();

    cache_miss_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(2), .MEM_TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if ($countones({bus.lk_en, bus.fill_en, bus.mem_req_valid, bus.cpu_resp_valid}) > 1)
            excl_viol++;
        if (bus.fill_en) fill_cnt++;
        if (bus.mem_req_valid && bus.mem_req_ready) mem_hs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_hit(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] exp_hc);
        chk("hit_ready_idle", 32'(bus.cpu_req_ready), 1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = addr;
        tick();
        bus.cpu_req_valid = 1'b0;
        chk("hit_lk_en", 32'(bus.lk_en), 1);
        chk("hit_lk_addr", bus.lk_addr, addr & 32'hFFFF_FFFC);
        chk("hit_ready_lookup", 32'(bus.cpu_req_ready), 0);
        bus.lk_hit  = 1'b1;
        bus.lk_data = data;
        tick();
        chk("hit_lk_en_check", 32'(bus.lk_en), 0);
        chk("hit_resp_early", 32'(bus.cpu_resp_valid), 0);
        chk("hit_ready_check", 32'(bus.cpu_req_ready), 0);
        tick();
        bus.lk_hit  = 1'b0;
        bus.lk_data = '0;
        chk("hit_resp_valid", 32'(bus.cpu_resp_valid), 1);
        chk("hit_resp_data", bus.cpu_resp_data, data);
        chk("hit_resp_hit", 32'(bus.cpu_resp_hit), 1);
        chk("hit_resp_err", 32'(bus.cpu_resp_err), 0);
        chk("hit_cnt", 32'(bus.hit_cnt), 32'(exp_hc));
        chk("hit_ready_resp", 32'(bus.cpu_req_ready), 0);
        tick();
        chk("hit_resp_drop", 32'(bus.cpu_resp_valid), 0);
        chk("hit_ready_back", 32'(bus.cpu_req_ready), 1);
    endtask

    // Drives a request to a lookup miss and leaves the FSM in its first MEM_REQ cycle.
    task automatic start_miss(input logic [31:0] addr);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = addr;
        tick();
        bus.cpu_req_valid = 1'b0;
        bus.lk_hit        = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_addr       = '0;
        bus.lk_hit         = 1'b0;
        bus.lk_data        = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(bus.cpu_req_ready), 0);
        chk("rst_lk_en", 32'(bus.lk_en), 0);
        chk("rst_mem_req", 32'(bus.mem_req_valid), 0);
        chk("rst_resp", 32'(bus.cpu_resp_valid), 0);
        chk("rst_hit_cnt", 32'(bus.hit_cnt), 0);
        chk("rst_miss_cnt", 32'(bus.miss_cnt), 0);
        rst = 1'b1;
        tick();

        // 1: hit
        run_hit(32'h0000_0040, 32'hDEAD_BEEF, 2'd1);

        // 2: miss, memory answers five cycles after the handshake
        bus.mem_req_ready = 1'b1;
        start_miss(32'h0000_0104);
        chk("m2_req_valid", 32'(bus.mem_req_valid), 1);
        chk("m2_mem_addr", bus.mem_addr, 32'h0000_0104);
        chk("m2_miss_cnt", 32'(bus.miss_cnt), 1);
        tick();
        bus.mem_req_ready = 1'b0;
        chk("m2_req_drop", 32'(bus.mem_req_valid), 0);
        repeat (4) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0041;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("m2_fill_en", 32'(bus.fill_en), 1);
        chk("m2_fill_addr", bus.fill_addr, 32'h0000_0104);
        chk("m2_fill_data", bus.fill_data, 32'h0000_0041);
        chk("m2_resp_early", 32'(bus.cpu_resp_valid), 0);
        tick();
        chk("m2_resp_valid", 32'(bus.cpu_resp_valid), 1);
        chk("m2_resp_data", bus.cpu_resp_data, 32'h0000_0041);
        chk("m2_resp_hit", 32'(bus.cpu_resp_hit), 0);
        chk("m2_resp_err", 32'(bus.cpu_resp_err), 0);
        chk("m2_fill_off", 32'(bus.fill_en), 0);
        tick();

        // 3: memory backpressure for four cycles, unaligned CPU address
        start_miss(32'h0000_020B);
        for (int i = 0; i < 4; i++) begin
            chk("m3_req_held", 32'(bus.mem_req_valid), 1);
            chk("m3_addr_held", bus.mem_addr, 32'h0000_0208);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        chk("m3_req_still", 32'(bus.mem_req_valid), 1);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0055;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("m3_fill_addr", bus.fill_addr, 32'h0000_0208);
        tick();
        chk("m3_resp_data", bus.cpu_resp_data, 32'h0000_0055);
        chk("m3_mem_hs", 32'(mem_hs), 2);
        chk("m3_miss_cnt", 32'(bus.miss_cnt), 2);
        tick();

        // 4: timeout after eight MEM_REQ/MEM_WAIT cycles
        bus.mem_req_ready = 1'b1;
        start_miss(32'h0000_0300);
        tick();
        bus.mem_req_ready = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.cpu_resp_valid) begin
                n = i;
                break;
            end
        end
        chk("m4_tmo_cycles", 32'(n), 7);
        chk("m4_resp_err", 32'(bus.cpu_resp_err), 1);
        chk("m4_resp_data", bus.cpu_resp_data, 0);
        chk("m4_resp_hit", 32'(bus.cpu_resp_hit), 0);
        chk("m4_no_fill", 32'(fill_cnt), 2);
        chk("m4_miss_sat", 32'(bus.miss_cnt), 3);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0099;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("m4_late_ready", 32'(bus.cpu_req_ready), 1);
        chk("m4_late_fill", 32'(bus.fill_en), 0);
        tick();
        chk("m4_late_resp", 32'(bus.cpu_resp_valid), 0);
        chk("m4_late_fill_cnt", 32'(fill_cnt), 2);

        // 5: reset while waiting on memory
        bus.mem_req_ready = 1'b1;
        start_miss(32'h0000_0400);
        tick();
        bus.mem_req_ready  = 1'b0;
        rst                = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0077;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("m5_ready_in_rst", 32'(bus.cpu_req_ready), 0);
        chk("m5_fill", 32'(bus.fill_en), 0);
        chk("m5_resp", 32'(bus.cpu_resp_valid), 0);
        chk("m5_hit_cnt", 32'(bus.hit_cnt), 0);
        chk("m5_miss_cnt", 32'(bus.miss_cnt), 0);
        rst = 1'b1;
        tick();
        chk("m5_idle", 32'(bus.cpu_req_ready), 1);
        chk("m5_fill_cnt", 32'(fill_cnt), 2);
        run_hit(32'h0000_0044, 32'h0000_1234, 2'd1);

        // 6: hit counter saturation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            run_hit(32'h0000_1000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), (i > 3) ? 2'd3 : 2'(i));
        end
        chk("m6_miss_cnt", 32'(bus.miss_cnt), 0);

        chk("strobe_exclusive", 32'(excl_viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
